// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared types and reset palette for the colour mapper pipeline
package color_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } flash_state_t;

    localparam rgb_t PAL_BLACK = 24'h000000;
    localparam rgb_t PAL_GRAY  = 24'h808080;
    localparam rgb_t PAL_WHITE = 24'hFFFFFF;
    localparam rgb_t PAL_BG    = 24'h3F007F;

    // The last entry is always the background, even when it aliases a low index.
    function automatic rgb_t pal_reset_entry(input int idx, input int num_colors);
        rgb_t val;
        val = PAL_BLACK;
        if (idx == num_colors - 1) val = PAL_BG;
        else if (idx == 1)         val = PAL_GRAY;
        else if (idx == 2)         val = PAL_WHITE;
        return val;
    endfunction

endpackage

// File: rtl/line_flash_fsm.sv
// rtl/line_flash_fsm.sv - frame-counted line-clear flash sequencer with latched row window
module line_flash_fsm
    import color_pkg::*;
#(
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_BLINKS = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_start_i,
    input  logic       flash_req_i,
    input  logic [9:0] flash_y_lo_i,
    input  logic [9:0] flash_y_hi_i,
    output logic       flash_busy_o,
    output logic       flash_on_o,
    output logic [9:0] y_lo_o,
    output logic [9:0] y_hi_o
);

    localparam int FW = $clog2(FLASH_FRAMES) + 1;
    localparam int BW = $clog2(FLASH_BLINKS) + 1;

    flash_state_t  state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [9:0]    lo_q, lo_d, hi_q, hi_d;
    logic          phase_end;

    assign phase_end = frame_start_i && (frame_q == FW'(FLASH_FRAMES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            frame_q <= '0;
            blink_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        blink_d = blink_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        case (state_q)
            IDLE: begin
                // A frame_start arriving with the request is not part of the first phase.
                if (flash_req_i) begin
                    lo_d    = flash_y_lo_i;
                    hi_d    = flash_y_hi_i;
                    frame_d = '0;
                    blink_d = '0;
                    state_d = ON;
                end
            end
            ON: begin
                if (phase_end) begin
                    frame_d = '0;
                    blink_d = blink_q + BW'(1);
                    state_d = (blink_q + BW'(1) == BW'(FLASH_BLINKS)) ? IDLE : OFF;
                end else if (frame_start_i) begin
                    frame_d = frame_q + FW'(1);
                end
            end
            OFF: begin
                if (phase_end) begin
                    frame_d = '0;
                    state_d = ON;
                end else if (frame_start_i) begin
                    frame_d = frame_q + FW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign flash_busy_o = (state_q != IDLE);
    assign flash_on_o   = (state_q == ON);
    assign y_lo_o       = lo_q;
    assign y_hi_o       = hi_q;

endmodule

// File: rtl/color_mapper_pipe.sv
// rtl/color_mapper_pipe.sv - 2-stage layer-priority palette mapper with line flash
// Optional GRADIENT_BG_EN: background blue ramps with DrawY, saturating at FF.
module color_mapper_pipe
    import color_pkg::*;
#(
    parameter int NUM_LAYERS   = 4,
    parameter int IDX_W        = 3,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_BLINKS = 3
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        pix_valid,
    input  logic [9:0]                  DrawX,
    input  logic [9:0]                  DrawY,
    input  logic                        startscreen,
    input  logic                        is_start,
    input  logic [NUM_LAYERS-1:0]       layer_hit,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic                        frame_start,
    input  logic                        flash_req,
    input  logic [9:0]                  flash_y_lo,
    input  logic [9:0]                  flash_y_hi,
    input  logic                        pal_we,
    input  logic [IDX_W-1:0]            pal_addr,
    input  logic [23:0]                 pal_data,
    output logic [7:0]                  VGA_R,
    output logic [7:0]                  VGA_G,
    output logic [7:0]                  VGA_B,
    output logic                        pix_valid_out,
    output logic                        flash_busy
);

    localparam int               NUM_COLORS = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] BG_IDX     = IDX_W'(NUM_COLORS - 1);

    logic [IDX_W-1:0] idx1_q, idx1_d;
    logic             bg1_q, bg1_d;
    logic             ss1_q;
    logic [9:0]       y1_q;
    logic             valid1_q;
    rgb_t             rgb2_q, rgb2_d;
    logic             valid2_q;
    rgb_t             pal_q [NUM_COLORS];
    logic             flash_on;
    logic [9:0]       y_lo, y_hi;
    logic             unused_drawx;

    assign unused_drawx = ^DrawX;

    line_flash_fsm #(
        .FLASH_FRAMES(FLASH_FRAMES),
        .FLASH_BLINKS(FLASH_BLINKS)
    ) u_flash (
        .clk_i        (Clk),
        .rst_i        (Reset),
        .frame_start_i(frame_start),
        .flash_req_i  (flash_req),
        .flash_y_lo_i (flash_y_lo),
        .flash_y_hi_i (flash_y_hi),
        .flash_busy_o (flash_busy),
        .flash_on_o   (flash_on),
        .y_lo_o       (y_lo),
        .y_hi_o       (y_hi)
    );

    // Scanning from the top layer down lets the lowest-numbered hit win.
    always_comb begin
        idx1_d = BG_IDX;
        bg1_d  = 1'b1;
        if (startscreen) begin
            if (is_start) begin
                idx1_d = '0;
                bg1_d  = 1'b0;
            end
        end else begin
            for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
                if (layer_hit[k]) begin
                    idx1_d = layer_idx[k*IDX_W +: IDX_W];
                    bg1_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx1_q   <= '0;
            bg1_q    <= 1'b0;
            ss1_q    <= 1'b0;
            y1_q     <= '0;
            valid1_q <= 1'b0;
        end else begin
            idx1_q   <= idx1_d;
            bg1_q    <= bg1_d;
            ss1_q    <= startscreen;
            y1_q     <= DrawY;
            valid1_q <= pix_valid;
        end
    end

    // Stage 2 samples the array before this edge's write lands, so a colliding lookup sees old data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_COLORS; i++) pal_q[i] <= pal_reset_entry(i, NUM_COLORS);
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_data;
        end
    end

`ifdef GRADIENT_BG_EN
    logic [8:0] b_sum;
`endif

    always_comb begin
        rgb2_d = pal_q[idx1_q];
`ifdef GRADIENT_BG_EN
        b_sum = {1'b0, rgb2_d.b} + {1'b0, y1_q[9:2]};
        if (bg1_q) rgb2_d.b = b_sum[8] ? 8'hFF : b_sum[7:0];
`endif
        if (flash_on && !ss1_q && !bg1_q && (y1_q >= y_lo) && (y1_q <= y_hi)) rgb2_d = PAL_WHITE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rgb2_q   <= PAL_BLACK;
            valid2_q <= 1'b0;
        end else begin
            rgb2_q   <= rgb2_d;
            valid2_q <= valid1_q;
        end
    end

    assign VGA_R         = rgb2_q.r;
    assign VGA_G         = rgb2_q.g;
    assign VGA_B         = rgb2_q.b;
    assign pix_valid_out = valid2_q;

endmodule

// File: doc/color_mapper_pipe.md
Name: color_mapper_pipe

Overview:
- Parametrised, pipelined successor to the combinational colour mapper for the Tetris VGA path.
- Resolves N prioritised layer hits per pixel into a palette index, then looks the index up in a writable RGB palette.
- Adds a frame-counted line-clear flash animation.
- Sits between the sprite/grid hit logic and the VGA output registers, with a fixed 2-cycle latency.

Parameters:
- NUM_LAYERS, 4: number of hit layers; index 0 has the highest priority.
- IDX_W, 3: palette index width; NUM_COLORS = 2**IDX_W.
- FLASH_FRAMES, 8: frames per flash ON or OFF phase (>=1).
- FLASH_BLINKS, 3: number of ON phases per flash request (>=1).

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-high.
- pix_valid  in  1  input pixel qualifier.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- startscreen  in  1  start-screen mode select.
- is_start  in  1  start-screen text hit.
- layer_hit  in  NUM_LAYERS  per-layer hit flags.
- layer_idx  in  NUM_LAYERS*IDX_W  per-layer palette index; layer k occupies bits [k*IDX_W +: IDX_W].
- frame_start  in  1  one-cycle pulse at each frame start.
- flash_req  in  1  one-cycle pulse requesting a line-clear flash.
- flash_y_lo  in  10  first flashing pixel row (inclusive).
- flash_y_hi  in  10  last flashing pixel row (inclusive).
- pal_we  in  1  palette write strobe.
- pal_addr  in  IDX_W  palette write address.
- pal_data  in  24  write data, {R,G,B}.
- VGA_R  out  8  red output.
- VGA_G  out  8  green output.
- VGA_B  out  8  blue output.
- pix_valid_out  out  1  pix_valid delayed by 2 cycles.
- flash_busy  out  1  high while the flash FSM is not IDLE.

Behaviour:
- Reset (async, active-high):
  - All pipeline registers, VGA_R/G/B, pix_valid_out and flash_busy go to 0; FSM goes to IDLE; counters clear.
  - Palette reset contents: entry 0 = 000000, entry 1 = 808080, entry 2 = FFFFFF, entry NUM_COLORS-1 = 3F007F (background), all other entries = 000000.
- Stage 1 (registered):
  - If startscreen=1: select is_start ? entry 0 : background.
  - Otherwise: select layer_idx of the lowest-numbered k with layer_hit[k]=1; if no layer hits, select background.
  - Also registers DrawY, the background flag and pix_valid.
- Stage 2 (registered): palette read of the stage-1 index, then the flash override, then the VGA outputs.
- Latency: output for the pixel presented in cycle t appears in cycle t+2. With pix_valid=0, the pipeline still advances and pix_valid_out=0.
- Palette writes:
  - A write with pal_we=1 in cycle t is visible to stage-2 lookups from cycle t+1 on.
  - A write to entry NUM_COLORS-1 changes the background colour.
  - Lookup and write in the same cycle on the same entry: the lookup returns the old data.
- Flash FSM states: IDLE, ON, OFF.
  - IDLE + flash_req: latch flash_y_lo/flash_y_hi, clear counters, go to ON.
  - ON: after FLASH_FRAMES frame_start pulses, increment the blink count. If the count equals FLASH_BLINKS go to IDLE, else go to OFF.
  - OFF: after FLASH_FRAMES frame_start pulses, go to ON.
  - flash_req while not IDLE is ignored; latched rows are not updated.
  - flash_req and frame_start in the same cycle in IDLE: the request is accepted and that frame_start is not counted.
  - Latched lo > hi: no pixel flashes, but the FSM timing is unchanged.
- Flash override: in ON, when not startscreen, for a non-background pixel with lo <= DrawY <= hi, the output is FFFFFF.
- Total flash duration: (2*FLASH_BLINKS-1)*FLASH_FRAMES frames.

Optional Feature:
- Macro: GRADIENT_BG_EN.
- Defined: background pixels (not startscreen text, not layer hits) take R,G from palette entry NUM_COLORS-1. B = palette B + DrawY[9:2], saturating at FF.
- Undefined: the background is a flat palette entry NUM_COLORS-1.
- The gradient does not apply to flashed or layer pixels.

Decomposition:
- Shared package color_pkg:
  - rgb_t (packed struct r, g, b, 8 bits each).
  - flash_state_t enum {IDLE, ON, OFF}.
  - Reset palette constants: PAL_BLACK, PAL_GRAY, PAL_WHITE, PAL_BG.
- One natural sub-module, line_flash_fsm: owns the FSM, the frame and blink counters and the row latches. It outputs flash_busy, flash_on, y_lo and y_hi.

Test Plan:
- Reset default mapping: release reset; layer_hit=0010, layer1 idx=2 -> RGB FFFFFF at t+2. layer_hit=0 -> 3F007F (flat build).
- Priority: layer_hit=1111, idx0=1, idx1=2 -> 808080. Toggle layer_hit to 1110 -> FFFFFF; check 2-cycle latency on both.
- Palette write: pal_we, addr 1, data 00FF00 in cycle t; a pixel with idx 1 entering stage 2 at t+1 -> 00FF00. Same-cycle lookup -> 808080.
- Flash, FLASH_FRAMES=2, BLINKS=2: flash_req with rows 100..115.
  - Block pixel at y=100 -> FFFFFF for 2 frames, idx colour for 2 frames, FFFFFF for 2 frames, then flash_busy=0.
  - y=116 never flashes.
  - A second flash_req while busy is ignored.
- Async reset mid-flash: Reset asserted between clock edges -> flash_busy=0, outputs 0 immediately, palette back to defaults.
- GRADIENT_BG_EN: background at DrawY=400 -> B = 7F+64 = E3. Palette B=F0 -> saturated FF.
